// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter in front of a 16 x 8 memory.
// One access is in flight at a time. Each access holds the memory bus for
// ACCESS_CYCLES cycles and then returns a one-cycle ack to the grantee.
module mem_bus_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  // Requester 0: CPU fetch/data port
  input  logic       req0,
  input  logic       we0,
  input  logic [3:0] addr0,
  input  logic [7:0] wdata0,
  output logic       ack0,
  output logic [7:0] rdata0,
  // Requester 1: interrupt-vector/auxiliary port
  input  logic       req1,
  input  logic       we1,
  input  logic [3:0] addr1,
  input  logic [7:0] wdata1,
  output logic       ack1,
  output logic [7:0] rdata1,
  // Memory side
  output logic [3:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  input  logic [7:0] mem_rdata,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  // Counter starts at ACCESS_CYCLES-1 so ACCESS lasts exactly ACCESS_CYCLES cycles.
  localparam logic [3:0] CntLoad = 4'(ACCESS_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_grant_q, last_grant_d;
  logic       grant_q, grant_d;
  logic [3:0] mem_addr_q, mem_addr_d;
  logic [7:0] mem_wdata_q, mem_wdata_d;
  logic       mem_we_q, mem_we_d;
  logic       ack0_q, ack0_d;
  logic       ack1_q, ack1_d;
  logic [7:0] rdata0_q, rdata0_d;
  logic [7:0] rdata1_q, rdata1_d;
  logic       busy_q, busy_d;
  logic       gnt;

  // Next-state logic: arbitration, access timing and completion.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = mem_we_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    gnt          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          // Under contention the requester not granted last wins.
          gnt          = (req0 && req1) ? ~last_grant_q : req1;
          grant_d      = gnt;
          last_grant_d = gnt;
          mem_we_d     = gnt ? we1 : we0;
          mem_addr_d   = gnt ? addr1 : addr0;
          mem_wdata_d  = gnt ? wdata1 : wdata0;
          cnt_d        = CntLoad;
          state_d      = StAccess;
        end
      end
      StAccess: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          mem_we_d = 1'b0;
          if (grant_q) begin
            ack1_d = 1'b1;
            if (!mem_we_q) rdata1_d = mem_rdata;
          end else begin
            ack0_d = 1'b1;
            if (!mem_we_q) rdata0_d = mem_rdata;
          end
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and registered outputs; reset aborts any access without an ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      mem_addr_q   <= 4'd0;
      mem_wdata_q  <= 8'd0;
      mem_we_q     <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= 8'd0;
      rdata1_q     <= 8'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      busy_q       <= busy_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: two instances (ACCESS_CYCLES 1 and 3), each with
// its own memory, checked every cycle against a timeline-based model.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

  localparam int NI = 2;
  localparam int unsigned AC0 = 1;
  localparam int unsigned AC1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst       [NI];
  logic       req       [NI][2];
  logic       we        [NI][2];
  logic [3:0] addr      [NI][2];
  logic [7:0] wdata     [NI][2];
  logic       ack       [NI][2];
  logic [7:0] rdata     [NI][2];
  logic [3:0] mem_addr  [NI];
  logic [7:0] mem_wdata [NI];
  logic       mem_we    [NI];
  logic [7:0] mem_rdata [NI];
  logic       busy      [NI];
  logic [7:0] mem       [NI][16];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_bus_arbiter #(.ACCESS_CYCLES(g == 0 ? AC0 : AC1)) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .req0      (req[g][0]),
      .we0       (we[g][0]),
      .addr0     (addr[g][0]),
      .wdata0    (wdata[g][0]),
      .ack0      (ack[g][0]),
      .rdata0    (rdata[g][0]),
      .req1      (req[g][1]),
      .we1       (we[g][1]),
      .addr1     (addr[g][1]),
      .wdata1    (wdata[g][1]),
      .ack1      (ack[g][1]),
      .rdata1    (rdata[g][1]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_we    (mem_we[g]),
      .mem_rdata (mem_rdata[g]),
      .busy      (busy[g])
    );
    assign mem_rdata[g] = mem[g][mem_addr[g]];
  end

  // Memory slave: reset contents word i = i*0x36 (word 4 = 0xD8).
  initial begin
    for (int k = 0; k < NI; k++)
      for (int i = 0; i < 16; i++) mem[k][i] = 8'(i * 8'h36);
    forever begin
      @(posedge clk);
      for (int k = 0; k < NI; k++)
        if (mem_we[k] === 1'b1) mem[k][mem_addr[k]] <= mem_wdata[k];
    end
  end

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int k, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d got=%h want=%h t=%0t", name, k, act, exp, $time);
    end
  endtask

  function automatic int ac_of(input int k);
    return (k == 0) ? int'(AC0) : int'(AC1);
  endfunction

  // Model: an access is a timeline of phases counted from its grant edge:
  // phases 0..AC-1 drive the bus, phase AC is the ack, phase AC+1 is idle again.
  int         cyc = 0;
  bit         m_inflight [NI];
  bit         m_who      [NI];
  bit         m_we       [NI];
  logic [3:0] m_addr     [NI];
  logic [7:0] m_wdata    [NI];
  int         m_start    [NI];
  bit         m_last     [NI];
  logic [7:0] m_rdata    [NI][2];
  logic [7:0] m_mem      [NI][16];

  initial begin
    for (int k = 0; k < NI; k++) begin
      m_inflight[k] = 1'b0;
      m_last[k]     = 1'b1;
      m_start[k]    = 0;
      for (int i = 0; i < 16; i++) m_mem[k][i] = 8'(i * 8'h36);
    end
  end

  task automatic model_step();
    int ph;
    bit who;
    for (int k = 0; k < NI; k++) begin
      ph = cyc - m_start[k];
      if (m_inflight[k] && m_we[k] && ph < ac_of(k)) m_mem[k][m_addr[k]] = m_wdata[k];
    end
    cyc++;
    for (int k = 0; k < NI; k++) begin
      if (rst[k] === 1'b1) begin
        m_inflight[k] = 1'b0;
        m_last[k]     = 1'b1;
        m_we[k]       = 1'b0;
        m_addr[k]     = 4'd0;
        m_wdata[k]    = 8'd0;
        m_rdata[k][0] = 8'd0;
        m_rdata[k][1] = 8'd0;
      end else if (!m_inflight[k]) begin
        if (req[k][0] || req[k][1]) begin
          who           = (req[k][0] && req[k][1]) ? !m_last[k] : req[k][1];
          m_who[k]      = who;
          m_last[k]     = who;
          m_we[k]       = we[k][who];
          m_addr[k]     = addr[k][who];
          m_wdata[k]    = wdata[k][who];
          m_start[k]    = cyc;
          m_inflight[k] = 1'b1;
        end
      end else begin
        ph = cyc - m_start[k];
        if (ph == ac_of(k) && !m_we[k]) m_rdata[k][m_who[k]] = m_mem[k][m_addr[k]];
        if (ph == ac_of(k) + 1) m_inflight[k] = 1'b0;
      end
    end
  endtask

  task automatic compare(input int k);
    int ph;
    bit e_we, e_ack0, e_ack1;
    ph     = cyc - m_start[k];
    e_we   = m_inflight[k] && m_we[k] && ph < ac_of(k);
    e_ack0 = m_inflight[k] && !m_who[k] && ph == ac_of(k);
    e_ack1 = m_inflight[k] && m_who[k] && ph == ac_of(k);
    chk("busy", k, {7'd0, busy[k]}, {7'd0, m_inflight[k]});
    chk("mem_we", k, {7'd0, mem_we[k]}, {7'd0, e_we});
    chk("mem_addr", k, {4'd0, mem_addr[k]}, {4'd0, m_addr[k]});
    chk("mem_wdata", k, mem_wdata[k], m_wdata[k]);
    chk("ack0", k, {7'd0, ack[k][0]}, {7'd0, e_ack0});
    chk("ack1", k, {7'd0, ack[k][1]}, {7'd0, e_ack1});
    chk("rdata0", k, rdata[k][0], m_rdata[k][0]);
    chk("rdata1", k, rdata[k][1], m_rdata[k][1]);
  endtask

  // Model advance and compare, at the falling edge after each rising edge.
  initial begin
    forever begin
      @(negedge clk);
      model_step();
      if (chk_en) for (int k = 0; k < NI; k++) compare(k);
    end
  end

  // Inputs change just after the falling edge, away from both the DUT and model.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int k);
    rst[k] = 1'b1;
    req[k][0] = 1'b0;
    req[k][1] = 1'b0;
    tick();
    rst[k] = 1'b0;
  endtask

  task automatic run_txn(input int k, input int r, input bit w, input logic [3:0] a,
                         input logic [7:0] d, output int lat, output int we_cyc);
    req[k][r] = 1'b1; we[k][r] = w; addr[k][r] = a; wdata[k][r] = d;
    lat = 0;
    we_cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (mem_we[k] === 1'b1) we_cyc++;
      if (ack[k][r] === 1'b1) begin
        lat = i;
        break;
      end
    end
    req[k][r] = 1'b0;
    chk("txn_ack_seen", k, {7'd0, lat != 0}, 8'd1);
    tick();
  endtask

  bit pending [NI][2];
  int lat, wc, n, last_t;
  int seq [8];

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1;
      for (int r = 0; r < 2; r++) begin
        req[k][r] = 1'b0; we[k][r] = 1'b0; addr[k][r] = 4'd0; wdata[k][r] = 8'd0;
        pending[k][r] = 1'b0;
      end
    end
    tick();
    tick();
    // Reset state: every output zero.
    for (int k = 0; k < NI; k++) begin
      chk("rst_busy", k, {7'd0, busy[k]}, 8'd0);
      chk("rst_mem_addr", k, {4'd0, mem_addr[k]}, 8'd0);
      chk("rst_mem_wdata", k, mem_wdata[k], 8'd0);
      chk("rst_mem_we", k, {7'd0, mem_we[k]}, 8'd0);
      chk("rst_ack0", k, {7'd0, ack[k][0]}, 8'd0);
      chk("rst_ack1", k, {7'd0, ack[k][1]}, 8'd0);
      chk("rst_rdata0", k, rdata[k][0], 8'd0);
      chk("rst_rdata1", k, rdata[k][1], 8'd0);
      rst[k] = 1'b0;
    end
    chk_en = 1'b1;

    // Single read of word 4 on the ACCESS_CYCLES=1 instance.
    req[0][0] = 1'b1; we[0][0] = 1'b0; addr[0][0] = 4'd4;
    tick();
    chk("t1_mem_addr", 0, {4'd0, mem_addr[0]}, 8'd4);
    chk("t1_busy", 0, {7'd0, busy[0]}, 8'd1);
    chk("t1_no_ack_yet", 0, {7'd0, ack[0][0]}, 8'd0);
    req[0][0] = 1'b0;
    tick();
    chk("t1_ack0", 0, {7'd0, ack[0][0]}, 8'd1);
    chk("t1_rdata0", 0, rdata[0][0], 8'hD8);
    chk("t1_model_rdata0", 0, m_rdata[0][0], 8'hD8);
    tick();
    chk("t1_idle", 0, {7'd0, busy[0]}, 8'd0);
    chk("t1_ack0_low", 0, {7'd0, ack[0][0]}, 8'd0);

    // Write 0x3C to word 9 through requester 1, then read it back.
    for (int k = 0; k < NI; k++) begin
      run_txn(k, 1, 1'b1, 4'd9, 8'h3C, lat, wc);
      chk("wr_latency", k, 8'(lat), 8'(ac_of(k) + 1));
      chk("wr_we_cycles", k, 8'(wc), 8'(ac_of(k)));
      chk("wr_rdata1_kept", k, rdata[k][1], 8'd0);
      chk("wr_ack1_one_cycle", k, {7'd0, ack[k][1]}, 8'd0);
      run_txn(k, 1, 1'b0, 4'd9, 8'h00, lat, wc);
      chk("rd_latency", k, 8'(lat), 8'(ac_of(k) + 1));
      chk("rd_we_cycles", k, 8'(wc), 8'd0);
      chk("rd_rdata1", k, rdata[k][1], 8'h3C);
      chk("rd_model_mem9", k, m_mem[k][9], 8'h3C);
    end

    // Continuous contention after reset: grants alternate starting with 0.
    do_reset(0);
    req[0][0] = 1'b1; we[0][0] = 1'b0; addr[0][0] = 4'd1;
    req[0][1] = 1'b1; we[0][1] = 1'b0; addr[0][1] = 4'd2;
    n = 0;
    for (int i = 0; i < 100 && n < 8; i++) begin
      tick();
      chk("cont_not_both", 0, {7'd0, ack[0][0] & ack[0][1]}, 8'd0);
      if (ack[0][0] === 1'b1 || ack[0][1] === 1'b1) begin
        seq[n] = (ack[0][1] === 1'b1) ? 1 : 0;
        n++;
      end
    end
    req[0][0] = 1'b0;
    req[0][1] = 1'b0;
    chk("cont_count", 0, 8'(n), 8'd8);
    for (int i = 0; i < n; i++) chk("cont_order", 0, 8'(seq[i]), 8'(i % 2));
    tick();
    tick();

    // ACCESS_CYCLES=3: req0 dropped in the first ACCESS cycle still completes.
    req[1][0] = 1'b1; we[1][0] = 1'b0; addr[1][0] = 4'd2;
    tick();
    req[1][0] = 1'b0;
    lat = 0;
    for (int i = 2; i <= 20; i++) begin
      tick();
      if (ack[1][0] === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk("drop_ack_time", 1, 8'(lat), 8'd4);
    chk("drop_rdata0", 1, rdata[1][0], 8'h6C);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n += int'(busy[1]);
    end
    chk("drop_stays_idle", 1, 8'(n), 8'd0);

    // Reset in the second ACCESS cycle of a write aborts without an ack.
    req[1][0] = 1'b1; we[1][0] = 1'b1; addr[1][0] = 4'd5; wdata[1][0] = 8'h77;
    tick();
    chk("abort_we_high", 1, {7'd0, mem_we[1]}, 8'd1);
    tick();
    rst[1] = 1'b1;
    req[1][0] = 1'b0;
    tick();
    rst[1] = 1'b0;
    chk("abort_we_low", 1, {7'd0, mem_we[1]}, 8'd0);
    chk("abort_idle", 1, {7'd0, busy[1]}, 8'd0);
    chk("abort_mem_addr", 1, {4'd0, mem_addr[1]}, 8'd0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n += int'(ack[1][0]) + int'(ack[1][1]);
    end
    chk("abort_no_ack", 1, 8'(n), 8'd0);

    // req1 held high: one access every ACCESS_CYCLES+2 cycles.
    req[1][1] = 1'b1; we[1][1] = 1'b0; addr[1][1] = 4'd9;
    n = 0;
    last_t = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (ack[1][1] === 1'b1) begin
        if (n > 0) chk("held_period", 1, 8'(i - last_t), 8'(AC1 + 2));
        last_t = i;
        n++;
      end
    end
    req[1][1] = 1'b0;
    chk("held_ack_count", 1, 8'(n), 8'd6);
    tick();
    tick();

    // Randomized traffic with occasional resets, checked by the model.
    for (int c = 0; c < 1200; c++) begin
      tick();
      for (int k = 0; k < NI; k++) begin
        if (rst[k]) rst[k] = 1'b0;
        if ($urandom_range(0, 199) == 0) begin
          rst[k] = 1'b1;
          pending[k][0] = 1'b0;
          pending[k][1] = 1'b0;
        end else begin
          for (int r = 0; r < 2; r++) begin
            if (pending[k][r] && ack[k][r] === 1'b1) pending[k][r] = 1'b0;
            if (!pending[k][r] && $urandom_range(0, 2) == 0) begin
              pending[k][r] = 1'b1;
              we[k][r]      = 1'($urandom_range(0, 1));
              addr[k][r]    = 4'($urandom_range(0, 15));
              wdata[k][r]   = 8'($urandom_range(0, 255));
            end
          end
        end
        req[k][0] = pending[k][0];
        req[k][1] = pending[k][1];
      end
    end
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b0;
      req[k][0] = 1'b0;
      req[k][1] = 1'b0;
    end
    for (int i = 0; i < 8; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

- Arbitrates the 16 x 8 main memory between two requesters.
  - Requester 0 is the CPU fetch/data port.
  - Requester 1 is the interrupt-vector/auxiliary port.
- Sits directly in front of the memory. It drives the memory's address, write-data and write-strobe inputs and captures its read data.
- Each requester uses a req/ack handshake. Contention is resolved round-robin, and exactly one access is in flight at a time.

## Interface

Parameters:
- ACCESS_CYCLES, 1 — cycles the memory bus is held per access (1..15).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 access request.
- we0  in  1  requester 0 write (1) / read (0).
- addr0  in  4  requester 0 word address.
- wdata0  in  8  requester 0 write data.
- ack0  out  1  one-cycle completion pulse to requester 0.
- rdata0  out  8  requester 0 read data, valid while ack0=1 and held afterwards.
- req1, we1, addr1, wdata1, ack1, rdata1: same as above, for requester 1.
- mem_addr  out  4  memory address.
- mem_wdata  out  8  memory write data.
- mem_we  out  1  memory write strobe (level).
- mem_rdata  in  8  memory read data, combinational from mem_addr.
- busy  out  1  high whenever FSM is not IDLE.

## Operation

- FSM states: IDLE, ACCESS, DONE. All outputs are registered.
- IDLE:
  - If neither req is high, remain in IDLE.
  - If exactly one req is high, grant that requester.
  - If both are high, grant the requester not granted last.
  - On a grant:
    - Latch the grantee's we/addr/wdata onto mem_we/mem_addr/mem_wdata.
    - Set last_grant to the grantee.
    - Load the cycle counter with ACCESS_CYCLES-1.
    - Go to ACCESS.
- ACCESS:
  - mem_addr/mem_wdata/mem_we are held constant.
  - While the counter is non-zero, decrement it and stay in ACCESS.
  - When the counter is zero:
    - On a read, capture mem_rdata into the grantee's rdata register.
    - Drive mem_we low.
    - Set the grantee's ack to 1.
    - Go to DONE.
- DONE:
  - The grantee's ack is high for this one cycle.
  - mem_addr/mem_wdata are held; mem_we=0.
  - Clear ack and go to IDLE.
- Writes leave the grantee's rdata unchanged. The non-granted requester's ack and rdata are never touched.
- Requester rules:
  - A requester holds req, we, addr and wdata stable from assertion until it sees ack.
  - If req drops mid-transaction, the access still completes and ack still pulses.
- A req still high in the cycle after ack is a new request and is re-arbitrated in IDLE.
- last_grant after reset is requester 1, so requester 0 wins the first contention.
- Reset values:
  - mem_addr=0, mem_wdata=0, mem_we=0.
  - ack0=ack1=0, rdata0=rdata1=0.
  - busy=0, state=IDLE, last_grant=1, counter=0.
- Reset mid-operation:
  - Any state returns to IDLE with the reset values on the next edge.
  - The aborted access issues no ack.
  - mem_we drops in the same edge.
- ACCESS_CYCLES outside 1..15 is a configuration error; the bench checks only legal values.

## Timing

- req sampled high in IDLE at edge n:
  - mem bus valid and busy=1 from edge n+1.
  - ack high from edge n+ACCESS_CYCLES+1 for exactly one cycle.
  - IDLE again at edge n+ACCESS_CYCLES+2.
- Back-to-back throughput is one access per ACCESS_CYCLES+2 cycles.
- With ACCESS_CYCLES=1: mem_we is high for exactly 1 cycle, and ack follows at +2.
- Under continuous contention, grants strictly alternate 0,1,0,1.
- rdata is sampled from mem_rdata on the final ACCESS edge. At that point mem_addr has been stable for ACCESS_CYCLES cycles.
- mem_addr changes only on the grant edge or on reset, never while mem_we=1.

## Test plan

- After rst, check all outputs are 0.
  - req0=1, we0=0, addr0=4, memory freshly reset (word 4 = 0xD8), ACCESS_CYCLES=1.
  - Required: mem_addr=4 at n+1, ack0=1 with rdata0=0xD8 at n+2, busy=0 at n+3.
- Write-then-read:
  - req1 writes 0x3C to addr 9: mem_we high exactly ACCESS_CYCLES cycles, ack1 pulse, rdata1 unchanged.
  - Then req1 reads addr 9: rdata1=0x3C.
- Contention: req0 and req1 held high continuously for 8 transactions. Required: acks alternate ack0, ack1, ack0, …, starting with ack0; never both high.
- ACCESS_CYCLES=3, req0 dropped in the first ACCESS cycle: access completes, ack0 pulses at n+4, FSM returns to IDLE and stays there.
- rst asserted in the second ACCESS cycle of a write (ACCESS_CYCLES=3): mem_we=0 and state IDLE at the next edge; no ack0/ack1 pulse.
- Single requester with req1 held high through ack: a second access starts at the IDLE edge after DONE; ack1 pulses every ACCESS_CYCLES+2 cycles.
